pulse_checker_x16: RTL and testbench

//  Receives the 16 test pulses plus the spare/trigger pulse from the padiwa pulse generator at the TDC/trigger side.

---
 rtl/pulse_checker_x16_pkg.sv | 25 ++
 rtl/pulse_meas_ch.sv | 114 +++++++++++
 rtl/pulse_checker_x16.sv | 142 ++++++++++++++
 tb/tb_pulse_checker_x16.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_checker_x16_pkg.sv
// Shared constants, read map and skew FSM encoding for the x16 pulse checker.
package pulse_checker_x16_pkg;

    localparam int NCH = 16;
    localparam int NIN = NCH + 1;   // pulse channels plus the spare/trigger input

    localparam logic [5:0] ADDR_PERIOD_BASE = 6'd16;
    localparam logic [5:0] ADDR_STATUS      = 6'd32;
    localparam logic [5:0] ADDR_SPARE       = 6'd33;

    typedef enum logic [1:0] {
        SKEW_IDLE    = 2'd0,
        SKEW_WINDOW  = 2'd1,
        SKEW_HOLDOFF = 2'd2
    } skew_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pulse_meas_ch.sv
// One pulse channel: 2-FF synchroniser, registered edge detect and the
// pulse / width / period / error measurements.
module pulse_meas_ch
    import pulse_checker_x16_pkg::*;
#(
    parameter int EXP_WIDTH  = 4,
    parameter int WIDTH_TOL  = 1,
    parameter int EXP_PERIOD = 11997,
    parameter int PERIOD_TOL = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_pulse,
    output logic        o_rise,
    output logic        o_level,
    output logic [15:0] o_pulse_cnt,
    output logic [7:0]  o_last_width,
    output logic [15:0] o_last_period,
    output logic [7:0]  o_err_cnt,
    output logic        o_err_flag
);

    localparam logic [7:0]  W_MIN = 8'(EXP_WIDTH - WIDTH_TOL);
    localparam logic [7:0]  W_MAX = 8'(EXP_WIDTH + WIDTH_TOL);
    localparam logic [15:0] P_MIN = 16'(EXP_PERIOD - PERIOD_TOL);
    localparam logic [15:0] P_MAX = 16'(EXP_PERIOD + PERIOD_TOL);

    logic        r_sync1, r_sync2, r_prev, r_rise, r_fall;
    logic [15:0] r_pulse_cnt, r_pcnt, r_last_period;
    logic [7:0]  r_wcnt, r_last_width, r_err_cnt;
    logic        r_in_pulse, r_seen_first, r_err_flag;
    logic        w_width_err, w_period_err;

    // Synchroniser and edge detect. The sync chain resets to "high" so an input
    // already high when reset releases does not produce a rising edge; the pulse
    // in progress is discarded and the next full pulse is measured.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= i_pulse;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_rise  <= r_sync2 & ~r_prev;
            r_fall  <= ~r_sync2 & r_prev;
        end
    end

    // A fall only counts if its rise was seen; a rise only checks period after the first one.
    assign w_width_err  = r_fall & r_in_pulse & ((r_wcnt < W_MIN) | (r_wcnt > W_MAX));
    assign w_period_err = r_rise & r_seen_first & ((r_pcnt < P_MIN) | (r_pcnt > P_MAX));

    // Measurement counters; clear wins over any edge or error in the same cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pulse_cnt   <= '0;
            r_pcnt        <= '0;
            r_last_period <= '0;
            r_wcnt        <= '0;
            r_last_width  <= '0;
            r_err_cnt     <= '0;
            r_in_pulse    <= 1'b0;
            r_seen_first  <= 1'b0;
            r_err_flag    <= 1'b0;
        end else if (i_clear) begin
            r_pulse_cnt   <= '0;
            r_pcnt        <= '0;
            r_last_period <= '0;
            r_wcnt        <= '0;
            r_last_width  <= '0;
            r_err_cnt     <= '0;
            r_in_pulse    <= 1'b0;
            r_seen_first  <= 1'b0;
            r_err_flag    <= 1'b0;
        end else begin
            if (r_rise) begin
                r_pulse_cnt  <= r_pulse_cnt + 16'd1;
                r_pcnt       <= 16'd1;
                r_wcnt       <= 8'd1;
                r_in_pulse   <= 1'b1;
                r_seen_first <= 1'b1;
                if (r_seen_first)
                    r_last_period <= r_pcnt;
            end else begin
                if (r_pcnt != 16'd0)
                    r_pcnt <= sat_inc16(r_pcnt);
                if (r_fall && r_in_pulse) begin
                    r_last_width <= r_wcnt;
                    r_in_pulse   <= 1'b0;
                end else if (r_in_pulse) begin
                    r_wcnt <= sat_inc8(r_wcnt);
                end
            end
            if (w_width_err || w_period_err) begin
                r_err_cnt  <= sat_inc8(r_err_cnt);
                r_err_flag <= 1'b1;
            end
        end
    end

    assign o_rise        = r_rise;
    assign o_level       = r_prev;
    assign o_pulse_cnt   = r_pulse_cnt;
    assign o_last_width  = r_last_width;
    assign o_last_period = r_last_period;
    assign o_err_cnt     = r_err_cnt;
    assign o_err_flag    = r_err_flag;

endmodule

// File: rtl/pulse_checker_x16.sv
// Checks the 16 padiwa test pulses plus spare: per-channel measurements,
// 17-input rise skew check and a registered slow-control read port.
module pulse_checker_x16
    import pulse_checker_x16_pkg::*;
#(
    parameter int EXP_WIDTH  = 4,
    parameter int WIDTH_TOL  = 1,
    parameter int EXP_PERIOD = 11997,
    parameter int PERIOD_TOL = 2,
    parameter int SKEW_WIN   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pulse_in,
    input  logic        spare_in,
    input  logic        clear,
    input  logic        rd_en,
    input  logic [5:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        err_any
);

    localparam logic [NIN-1:0] ALL_SEEN  = {NIN{1'b1}};
    localparam logic [7:0]     SKEW_LAST = 8'(SKEW_WIN);

    logic [15:0]    w_pulse_cnt   [NCH];
    logic [7:0]     w_last_width  [NCH];
    logic [15:0]    w_last_period [NCH];
    logic [7:0]     w_err_cnt     [NCH];
    logic [NCH-1:0] w_err_flag;
    logic [NIN-1:0] w_rise, w_level;
    logic [15:0]    w_spare_pulse_cnt;
    logic [7:0]     w_spare_unused_width, w_spare_unused_err_cnt;
    logic [15:0]    w_spare_unused_period;
    logic           w_spare_unused_err_flag;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        pulse_meas_ch #(
            .EXP_WIDTH(EXP_WIDTH), .WIDTH_TOL(WIDTH_TOL),
            .EXP_PERIOD(EXP_PERIOD), .PERIOD_TOL(PERIOD_TOL)
        ) u_ch (
            .i_clk(clk), .i_rst(reset), .i_clear(clear), .i_pulse(pulse_in[g]),
            .o_rise(w_rise[g]), .o_level(w_level[g]),
            .o_pulse_cnt(w_pulse_cnt[g]), .o_last_width(w_last_width[g]),
            .o_last_period(w_last_period[g]), .o_err_cnt(w_err_cnt[g]),
            .o_err_flag(w_err_flag[g])
        );
    end

    pulse_meas_ch #(
        .EXP_WIDTH(EXP_WIDTH), .WIDTH_TOL(WIDTH_TOL),
        .EXP_PERIOD(EXP_PERIOD), .PERIOD_TOL(PERIOD_TOL)
    ) u_spare (
        .i_clk(clk), .i_rst(reset), .i_clear(clear), .i_pulse(spare_in),
        .o_rise(w_rise[NCH]), .o_level(w_level[NCH]),
        .o_pulse_cnt(w_spare_pulse_cnt), .o_last_width(w_spare_unused_width),
        .o_last_period(w_spare_unused_period), .o_err_cnt(w_spare_unused_err_cnt),
        .o_err_flag(w_spare_unused_err_flag)
    );

    skew_state_t    r_skew_state;
    logic [NIN-1:0] r_seen;
    logic [7:0]     r_win_cnt;
    logic [15:0]    r_skew_err_cnt;
    logic           w_win_active;
    logic [NIN-1:0] w_mask;
    logic [7:0]     w_win_next;
    logic           w_win_done;

    // The first cycle of a window is the IDLE cycle that saw the opening edge.
    assign w_win_active = (r_skew_state == SKEW_WINDOW);
    assign w_mask       = w_win_active ? (r_seen | w_rise) : w_rise;
    assign w_win_next   = w_win_active ? (r_win_cnt + 8'd1) : 8'd1;
    assign w_win_done   = (w_win_next >= SKEW_LAST);

    // Skew FSM: open a window on the first rise, collect rises, then hold off until all inputs are low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_skew_state   <= SKEW_IDLE;
            r_seen         <= '0;
            r_win_cnt      <= '0;
            r_skew_err_cnt <= '0;
        end else if (clear) begin
            r_skew_state   <= SKEW_HOLDOFF;
            r_seen         <= '0;
            r_win_cnt      <= '0;
            r_skew_err_cnt <= '0;
        end else begin
            case (r_skew_state)
                SKEW_IDLE, SKEW_WINDOW: begin
                    if (w_win_active || (|w_rise)) begin
                        r_seen    <= w_mask;
                        r_win_cnt <= w_win_next;
                        if (w_win_done) begin
                            if (w_mask != ALL_SEEN)
                                r_skew_err_cnt <= sat_inc16(r_skew_err_cnt);
                            r_skew_state <= SKEW_HOLDOFF;
                        end else begin
                            r_skew_state <= SKEW_WINDOW;
                        end
                    end
                end
                SKEW_HOLDOFF: begin
                    if (!(|w_level))
                        r_skew_state <= SKEW_IDLE;
                end
                default: r_skew_state <= SKEW_IDLE;
            endcase
        end
    end

    logic [31:0] w_rd_mux;

    // Read mux over the current (pre-update) register values.
    always_comb begin
        w_rd_mux = 32'h0;
        if (rd_addr < ADDR_PERIOD_BASE)
            w_rd_mux = {w_err_cnt[rd_addr[3:0]], w_last_width[rd_addr[3:0]], w_pulse_cnt[rd_addr[3:0]]};
        else if (rd_addr < ADDR_STATUS)
            w_rd_mux = {16'h0, w_last_period[rd_addr[3:0]]};
        else if (rd_addr == ADDR_STATUS)
            w_rd_mux = {w_err_flag, r_skew_err_cnt};
        else if (rd_addr == ADDR_SPARE)
            w_rd_mux = {16'h0, w_spare_pulse_cnt};
    end

    // Registered read port with one cycle of latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= w_rd_mux;
        end
    end

    assign err_any = (|w_err_flag) | (r_skew_err_cnt != 16'd0);

endmodule

// File: tb/tb_pulse_checker_x16.sv
// Randomised pulse-round bench for pulse_checker_x16 with a per-pulse reference model.
module tb_pulse_checker_x16;

    localparam int NIN        = 17;
    localparam int EXP_WIDTH  = 4;
    localparam int WIDTH_TOL  = 1;
    localparam int EXP_PERIOD = 100;   // shortened period keeps the run short
    localparam int PERIOD_TOL = 2;
    localparam int SKEW_WIN   = 3;
    localparam int RD0        = 30;    // cycle in each round where the read sweep starts

    logic        clk = 1'b0;
    logic        reset, clear, rd_en, spare_in, rd_valid, err_any;
    logic [15:0] pulse_in;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;

    always #5 clk = ~clk;

    pulse_checker_x16 #(
        .EXP_WIDTH(EXP_WIDTH), .WIDTH_TOL(WIDTH_TOL), .EXP_PERIOD(EXP_PERIOD),
        .PERIOD_TOL(PERIOD_TOL), .SKEW_WIN(SKEW_WIN)
    ) dut (
        .clk(clk), .reset(reset), .pulse_in(pulse_in), .spare_in(spare_in),
        .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .err_any(err_any)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: one entry per input, index 16 is the spare.
    int m_pcnt[NIN], m_lw[NIN], m_lp[NIN], m_err[NIN], m_prev_off[NIN];
    bit m_flag[NIN], m_has_prev[NIN];
    int m_skew, m_prev_len;
    int drv_off[NIN], drv_w[NIN];

    function automatic void model_reset();
        for (int c = 0; c < NIN; c++) begin
            m_pcnt[c] = 0; m_lw[c] = 0; m_lp[c] = 0; m_err[c] = 0;
            m_flag[c] = 0; m_has_prev[c] = 0; m_prev_off[c] = 0;
        end
        m_skew = 0;
    endfunction

    function automatic void add_err(input int c);
        if (m_err[c] < 255) m_err[c]++;
        m_flag[c] = 1;
    endfunction

    // Apply one round in which every input pulses once at its offset with its width.
    function automatic void model_round();
        int lo = 1000, hi = -1, per;
        for (int c = 0; c < NIN; c++) begin
            m_pcnt[c] = (m_pcnt[c] + 1) % 65536;
            if (m_has_prev[c]) begin
                per = m_prev_len + drv_off[c] - m_prev_off[c];
                m_lp[c] = per;
                if (per < EXP_PERIOD - PERIOD_TOL || per > EXP_PERIOD + PERIOD_TOL) add_err(c);
            end
            m_has_prev[c] = 1;
            m_prev_off[c] = drv_off[c];
            m_lw[c] = drv_w[c];
            if (drv_w[c] < EXP_WIDTH - WIDTH_TOL || drv_w[c] > EXP_WIDTH + WIDTH_TOL) add_err(c);
            if (drv_off[c] < lo) lo = drv_off[c];
            if (drv_off[c] > hi) hi = drv_off[c];
        end
        if (hi - lo >= SKEW_WIN && m_skew < 65535) m_skew++;
    endfunction

    function automatic logic [31:0] exp_word(input int a);
        logic [31:0] v;
        logic [15:0] fl;
        v = 32'h0;
        fl = 16'h0;
        for (int c = 0; c < 16; c++) fl[c] = m_flag[c];
        if (a < 16)       v = {8'(m_err[a]), 8'(m_lw[a]), 16'(m_pcnt[a])};
        else if (a < 32)  v = {16'h0, 16'(m_lp[a-16])};
        else if (a == 32) v = {fl, 16'(m_skew)};
        else if (a == 33) v = {16'h0, 16'(m_pcnt[16])};
        return v;
    endfunction

    function automatic logic exp_err_any();
        logic r;
        r = (m_skew != 0);
        for (int c = 0; c < 16; c++) r = r | m_flag[c];
        return r;
    endfunction

    function automatic void set_nominal();
        for (int c = 0; c < NIN; c++) begin
            drv_off[c] = 0;
            drv_w[c]   = EXP_WIDTH;
        end
    endfunction

    // One round of len cycles: pulses at the start, then a full read sweep.
    task automatic run_round(input int len, input bit pulses, input bit do_clear,
                             input bit do_reset, input string tag);
        bit          rd_pend, v;
        int          rd_a, pend_a;
        logic [31:0] rd_exp;
        rd_pend = 0;
        pend_a  = 0;
        rd_exp  = 32'h0;
        if (pulses && !do_clear && !do_reset) model_round();
        for (int t = 0; t < len; t++) begin
            @(negedge clk);
            if (rd_pend) begin
                check_val($sformatf("%s/rd_data[%0d]", tag, pend_a), rd_data, rd_exp);
                check_val($sformatf("%s/rd_valid", tag), 32'(rd_valid), 32'd1);
                rd_pend = 0;
            end else if (t == RD0 + 36) begin
                check_val($sformatf("%s/rd_valid_low", tag), 32'(rd_valid), 32'd0);
            end
            for (int c = 0; c < NIN; c++) begin
                v = pulses && (t >= drv_off[c]) && (t < drv_off[c] + drv_w[c]);
                if (c < 16) pulse_in[c] = v;
                else        spare_in = v;
            end
            if (do_clear) begin
                if (t == 2) check_val($sformatf("%s/err_any_pre", tag), 32'(err_any), 32'(exp_err_any()));
                if (t == 3) begin
                    clear = 1'b1;
                    model_reset();
                end else begin
                    clear = 1'b0;
                end
                if (t == 4) check_val($sformatf("%s/err_any_clr", tag), 32'(err_any), 32'd0);
            end
            if (do_reset) begin
                if (t == 2) begin
                    reset = 1'b1;
                    model_reset();
                end else if (t == 3) begin
                    check_val($sformatf("%s/rst_rd_valid", tag), 32'(rd_valid), 32'd0);
                    check_val($sformatf("%s/rst_rd_data", tag), rd_data, 32'd0);
                    check_val($sformatf("%s/rst_err_any", tag), 32'(err_any), 32'd0);
                    reset = 1'b0;
                end
            end
            if (t >= RD0 && t < RD0 + 35) begin
                rd_a    = (t - RD0 < 34) ? (t - RD0) : $urandom_range(34, 63);
                rd_en   = 1'b1;
                rd_addr = 6'(rd_a);
                rd_exp  = exp_word(rd_a);
                pend_a  = rd_a;
                rd_pend = 1;
            end else begin
                rd_en = 1'b0;
            end
            if (t == RD0) check_val($sformatf("%s/err_any", tag), 32'(err_any), 32'(exp_err_any()));
        end
        m_prev_len = len;
    endtask

    int len, c_sel;

    initial begin
        reset = 1'b1; clear = 1'b0; rd_en = 1'b0; rd_addr = '0;
        pulse_in = '0; spare_in = 1'b0;
        model_reset();
        m_prev_len = 0;
        set_nominal();
        repeat (3) @(negedge clk);
        check_val("reset/rd_valid", 32'(rd_valid), 32'd0);
        check_val("reset/rd_data", rd_data, 32'd0);
        check_val("reset/err_any", 32'(err_any), 32'd0);
        reset = 1'b0;

        run_round(80, 0, 0, 0, "idle");

        // Five nominal pulses on every input.
        for (int r = 0; r < 5; r++) run_round(EXP_PERIOD, 1, 0, 0, "nominal");

        // Channel 7 over-wide pulse.
        drv_w[7] = 6;
        run_round(EXP_PERIOD, 1, 0, 0, "ch7_wide");
        set_nominal();

        // Long spacing gives every channel a period error on the following pulse.
        run_round(EXP_PERIOD + 8, 1, 0, 0, "long_gap");
        run_round(EXP_PERIOD, 1, 0, 0, "after_gap");

        // Channel 12 late by 3 (skew error) then by 2 (inside window).
        drv_off[12] = 3;
        run_round(EXP_PERIOD, 1, 0, 0, "ch12_skew3");
        drv_off[12] = 2;
        run_round(EXP_PERIOD, 1, 0, 0, "ch12_skew2");
        set_nominal();
        run_round(EXP_PERIOD, 1, 0, 0, "nominal2");

        // Random rounds: occasional gap, skew and width disturbances.
        for (int r = 0; r < 20; r++) begin
            set_nominal();
            len = EXP_PERIOD;
            if ($urandom_range(0, 9) < 3) len = EXP_PERIOD + $urandom_range(0, 6) - 3;
            if ($urandom_range(0, 1) == 1) begin
                c_sel = $urandom_range(0, NIN - 1);
                drv_off[c_sel] = $urandom_range(1, 3);
            end
            if ($urandom_range(0, 1) == 1) begin
                c_sel = $urandom_range(0, NIN - 1);
                drv_w[c_sel] = $urandom_range(2, 6);
            end
            run_round(len, 1, 0, 0, "random");
        end

        // Clear on the rising-edge cycle; first pulse afterwards has no period check.
        set_nominal();
        run_round(EXP_PERIOD + 7, 1, 1, 0, "clear");
        run_round(EXP_PERIOD, 1, 0, 0, "post_clear1");
        run_round(EXP_PERIOD, 1, 0, 0, "post_clear2");

        // Asynchronous reset in the middle of a pulse, then two clean pulses.
        drv_w = '{default: 6};
        run_round(EXP_PERIOD + 5, 1, 0, 1, "reset_mid");
        set_nominal();
        run_round(EXP_PERIOD, 1, 0, 0, "post_reset1");
        run_round(EXP_PERIOD, 1, 0, 0, "post_reset2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
